// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The ALU opcode map matches the execute-stage ALU encoding.
package mul_seq_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_LSL  = 4'b1000;
  localparam logic [3:0] ALU_LSR  = 4'b1001;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU shared with the execute stage.
// The zero flag reflects the result of whichever operation is selected.
module alu
  import mul_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    result = '0;
    unique case (alu_control)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_PASS: result = a;
      ALU_LSL:  result = a << b[5:0];
      ALU_LSR:  result = a >> b[5:0];
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle 64-bit multiplier: one ALU add per iteration, low 64 product bits out.
// Handshake flags decode from the state register only.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] product,
  output logic              product_zero,
  output logic              busy
);

  mul_state_t        state, state_next;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] alu_b, alu_sum;
  logic              alu_zero;
  logic              last_iter;

  // Outside RUN the addend is zero, so the ALU passes acc through and its zero flag tests acc.
  assign alu_b = (state == RUN && mplier[0]) ? mcand : '0;

  alu u_alu (
    .a           (acc),
    .b           (alu_b),
    .alu_control (ALU_ADD),
    .result      (alu_sum),
    .zero        (alu_zero)
  );

  assign last_iter = (cnt == CNT_W'(DATA_W - 1)) ||
                     (EARLY_EXIT && (mplier[DATA_W-1:1] == '0));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= alu_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // acc is frozen in DONE, so product stays stable under backpressure.
  assign product      = acc;
  assign product_zero = alu_zero;

endmodule

// File: tb/tb_mul_seq.sv
// Randomized self-checking bench for mul_seq: one unit with early exit, one without,
// compared against plain a*b arithmetic and a latency rule derived from the multiplier MSB.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        product_zero [2];
  logic        busy      [2];
  logic [63:0] a         [2];
  logic [63:0] b         [2];
  logic [63:0] product   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_seq #(.EARLY_EXIT(1'b1)) dut_early (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .product(product[0]), .product_zero(product_zero[0]), .busy(busy[0])
  );

  mul_seq #(.EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .product(product[1]), .product_zero(product_zero[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference latency: number of significant multiplier bits (at least 1), or 64 without early exit.
  function automatic int model_lat(input int u, input logic [63:0] bv);
    if (u == 1) return 64;
    for (int i = 63; i >= 0; i--)
      if (bv[i]) return i + 1;
    return 1;
  endfunction

  task automatic check_reset_values(input string tag);
    for (int u = 0; u < 2; u++) begin
      check({tag, "/in_ready"},     64'(in_ready[u]),     64'd1);
      check({tag, "/out_valid"},    64'(out_valid[u]),    64'd0);
      check({tag, "/busy"},         64'(busy[u]),         64'd0);
      check({tag, "/product"},      product[u],           64'd0);
      check({tag, "/product_zero"}, 64'(product_zero[u]), 64'd1);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic accept(input int u, input logic [63:0] av, input logic [63:0] bv, input string tag);
    int n = 0;
    while (!in_ready[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ready_wait"}, 64'(in_ready[u]), 64'd1);
    a[u] = av;
    b[u] = bv;
    in_valid[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    check({tag, "/busy"}, 64'(busy[u]), 64'd1);
  endtask

  task automatic run_op(input int u, input logic [63:0] av, input logic [63:0] bv,
                        input int hold, input string tag);
    logic [63:0] exp_p;
    int          lat;
    exp_p = av * bv;
    accept(u, av, bv, tag);
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "/latency"},      64'(lat),             64'(model_lat(u, bv)));
    check({tag, "/product"},      product[u],           exp_p);
    check({tag, "/product_zero"}, 64'(product_zero[u]), 64'(exp_p == 64'd0));
    for (int i = 0; i < hold; i++) begin
      in_valid[u] = 1'b1;
      a[u] = {$urandom, $urandom};
      b[u] = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      check({tag, "/hold_product"},   product[u],         exp_p);
      check({tag, "/hold_in_ready"},  64'(in_ready[u]),   64'd0);
      check({tag, "/hold_out_valid"}, 64'(out_valid[u]),  64'd1);
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[u] = 1'b0;
    check({tag, "/rel_in_ready"},  64'(in_ready[u]),  64'd1);
    check({tag, "/rel_out_valid"}, 64'(out_valid[u]), 64'd0);
  endtask

  initial begin
    logic [63:0] av, bv;
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b0; a[u] = '0; b[u] = '0;
    end
    #2;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(0, 64'd3, 64'd5, 0, "a3b5");
    run_op(0, 64'h1234, 64'd0, 0, "b_zero");
    run_op(0, 64'h8000_0000_0000_0000, 64'd2, 0, "wrap");
    run_op(0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "b_all_ones");
    run_op(0, 64'd11, 64'd13, 10, "backpressure");
    run_op(0, 64'd21, 64'd2, 0, "after_bp");

    // Asynchronous reset one cycle into RUN of 7*9: acc already holds 7*(9&1).
    accept(0, 64'd7, 64'd9, "rst_run");
    @(posedge clk);
    @(negedge clk);
    check("rst_run/mid_product", product[0], 64'd7);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(0, 64'd6, 64'd7, 0, "post_reset");

    run_op(1, 64'd3, 64'd5, 0, "full_a3b5");
    for (int i = 0; i < 3; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_op(1, av, bv, 0, "full_rand");
    end

    for (int i = 0; i < 24; i++) begin
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) av = '0;
      if ($urandom_range(0, 7) == 0) bv = '0;
      run_op(0, av, bv, $urandom_range(0, 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
